// File: rtl/gbfofm_pkg.sv
// Shared definitions for the GBFOFM port arbiter: default widths and the
// issue-stage command encoding.
package gbfofm_pkg;

  localparam int DEF_SRAM_DEPTH_BIT = 6;
  localparam int DEF_SRAM_WIDTH     = 28;
  localparam int DEF_RD_FIFO_DEPTH  = 4;
  localparam int DEF_MAX_WAIT       = 8;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2
  } cmd_e;

endpackage

// File: rtl/gbfofm_rd_fifo.sv
// Read-return FIFO: WIDTH x DEPTH (DEPTH a power of 2), simultaneous push/pop,
// occupancy exposed as count. Storage is reset so the head reads 0 after reset.
module gbfofm_rd_fifo
  import gbfofm_pkg::*;
#(
  parameter int WIDTH = DEF_SRAM_WIDTH,
  parameter int DEPTH = DEF_RD_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The arbiter's read credit must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/gbfofm_port_arbiter.sv
// Single-port GBFOFM sequencer: write/read arbitration, registered SRAM issue,
// in-flight read tracking and credit-protected read return.
// Optional read starvation guard: define GBFOFM_STARVE_GUARD_EN.
module gbfofm_port_arbiter
  import gbfofm_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = DEF_SRAM_DEPTH_BIT,
  parameter int SRAM_WIDTH     = DEF_SRAM_WIDTH,
  parameter int RD_FIFO_DEPTH  = DEF_RD_FIFO_DEPTH,
  parameter int MAX_WAIT       = DEF_MAX_WAIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req,
  input  logic [SRAM_DEPTH_BIT-1:0] wr_addr,
  input  logic [SRAM_WIDTH-1:0]     wr_data,
  output logic                      wr_ack,
  input  logic                      rd_req,
  input  logic [SRAM_DEPTH_BIT-1:0] rd_addr,
  output logic                      rd_ack,
  output logic                      rd_valid,
  output logic [SRAM_WIDTH-1:0]     rd_data,
  input  logic                      rd_ready,
  output logic                      write_en,
  output logic                      read_en,
  output logic [SRAM_DEPTH_BIT-1:0] addr_w,
  output logic [SRAM_DEPTH_BIT-1:0] addr_r,
  output logic [SRAM_WIDTH-1:0]     data_in,
  input  logic [SRAM_WIDTH-1:0]     data_out,
  output logic                      busy
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  cmd_e             cmd_q;
  logic             rd_pend_d;
  logic [1:0]       inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             rd_cred;

  // Occupancy counts every accepted read not yet popped, so no push can overflow.
  assign rd_cred = ({1'b0, fifo_count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(RD_FIFO_DEPTH);

`ifdef GBFOFM_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;

  assign starve = (wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    wr_ack = rst_n & wr_req & ~(starve & rd_req & rd_cred);
    rd_ack = rst_n & rd_req & rd_cred & (~wr_req | starve);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (rd_ack || !rd_req) begin
      wait_cnt <= '0;
    end else if (wr_req && rd_cred && !starve) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);

  always_comb begin
    wr_ack = rst_n & wr_req;
    rd_ack = rst_n & rd_req & rd_cred & ~wr_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= CMD_IDLE;
      addr_w  <= '0;
      addr_r  <= '0;
      data_in <= '0;
    end else if (wr_ack) begin
      cmd_q   <= CMD_WR;
      addr_w  <= wr_addr;
      data_in <= wr_data;
    end else if (rd_ack) begin
      cmd_q   <= CMD_RD;
      addr_r  <= rd_addr;
    end else begin
      cmd_q   <= CMD_IDLE;
    end
  end

  assign write_en = (cmd_q == CMD_WR);
  assign read_en  = (cmd_q == CMD_RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_d <= 1'b0;
      inflight  <= '0;
    end else begin
      rd_pend_d <= read_en;
      case ({rd_ack, rd_pend_d})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  gbfofm_rd_fifo #(
    .WIDTH (SRAM_WIDTH),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_d),
    .push_data (data_out),
    .pop       (rd_valid & rd_ready),
    .head      (rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign busy     = (inflight != '0) | (fifo_count != '0);

endmodule
